fabric_cfg_loader: RTL and testbench

Word-to-bitstream configuration loader that sits directly upstream of the fabric tile scan chain (`mac_tile` and its neighbours). It accepts configuration words from a host over a valid/ready handshake, serialises them LSB-first onto the chain's `shift_in`, and drives `cen` for exactly `CHAIN_LEN` shift cycles. It then pulses `cset` to commit the shifted bits into the tiles' active configuration. It replaces the open-loop shift register currently used to preload tiles.

---
 rtl/fabric_cfg_pkg.sv | 24 ++
 rtl/fabric_cfg_crc16.sv | 27 ++
 rtl/fabric_cfg_loader.sv | 153 +++++++++++++++
 tb/tb_fabric_cfg_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg: shared types and constants for the fabric configuration loader.
// Holds the loader state encoding, the CRC-16-CCITT constants and the single-bit
// CRC step used by the optional integrity checksum (FABRIC_CFG_LOADER_CRC_EN).

package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SET  = 2'd2,
        DONE = 2'd3
    } cfg_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16 update for a single serial bit.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc_cur, input logic bit_in);
        logic fb;
        fb = crc_cur[15] ^ bit_in;
        return {crc_cur[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fabric_cfg_crc16.sv
// fabric_cfg_crc16: bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first).
// Only instantiated by fabric_cfg_loader when FABRIC_CFG_LOADER_CRC_EN is defined.
// init re-seeds the register; en folds in bit_in. init takes priority over en.

module fabric_cfg_crc16
    import fabric_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    // Checksum register: seeded on reset/init, one update per shifted chain bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc <= CRC16_INIT;
        end else if (init) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_next(crc, bit_in);
        end
    end

endmodule

// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: accepts host configuration words over valid/ready, shifts
// them LSB-first onto the tile scan chain with cen, then strobes cset to commit.
// Optional macro FABRIC_CFG_LOADER_CRC_EN adds a 16-bit CRC of the shifted bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// LOAD  | accepting words and shifting until CHAIN_LEN bits have gone out
// SET   | cset high for one cycle to commit the chain
// DONE  | done high for one cycle, then back to IDLE

module fabric_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 3983,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              cset,
    output logic              busy,
    output logic              done
`ifdef FABRIC_CFG_LOADER_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);

    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int REM_W   = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] N_WORDS_C   = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [REM_W-1:0] REM_ONE     = REM_W'(1);
    // The accepted word's bit 0 goes out immediately, so WORD_W-1 bits stay buffered.
    localparam logic [REM_W-1:0] REM_AFTER_LOAD = REM_W'(WORD_W - 1);

    cfg_state_t        state;
    logic [WORD_W-1:0] sreg;
    logic [REM_W-1:0]  rem;          // bits still buffered in sreg, not yet on shift_out
    logic [CNT_W-1:0]  bits_left;    // down-counter of chain bits still to send
    logic [CNT_W-1:0]  words_taken;

    logic accept;
    logic emit;
    logic emit_bit;

    // A new word is taken only once the buffer has drained, which lets a word
    // accepted on the last-bit cycle continue the stream with no gap.
    assign word_ready = (state == LOAD) && (rem == '0) && (words_taken < N_WORDS_C);
    assign accept     = word_ready && word_valid;

    // A bit leaves whenever the chain still needs bits and one is available,
    // either freshly accepted or buffered. Excess bits of the last word never emit.
    assign emit     = (state == LOAD) && (bits_left != '0) && (accept || (rem != '0));
    assign emit_bit = accept ? word_in[0] : sreg[0];

    // Sequencer FSM with registered chain-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sreg        <= '0;
            rem         <= '0;
            bits_left   <= '0;
            words_taken <= '0;
            shift_out   <= 1'b0;
            cen         <= 1'b0;
            cset        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            shift_out <= emit ? emit_bit : 1'b0;
            cen       <= emit;
            cset      <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        bits_left   <= CHAIN_LEN_C;
                        words_taken <= '0;
                        rem         <= '0;
                        sreg        <= '0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        sreg        <= word_in >> 1;
                        rem         <= REM_AFTER_LOAD;
                        words_taken <= words_taken + CNT_ONE;
                    end else if (rem != '0) begin
                        sreg <= sreg >> 1;
                        rem  <= rem - REM_ONE;
                    end

                    if (emit) begin
                        bits_left <= bits_left - CNT_ONE;
                    end

                    // Terminal count: the final bit is on shift_out this cycle.
                    if (bits_left == '0) begin
                        state <= SET;
                        cset  <= 1'b1;
                        rem   <= '0;
                        sreg  <= '0;
                    end
                end

                SET: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FABRIC_CFG_LOADER_CRC_EN
    logic crc_init;

    assign crc_init = (state == IDLE) && start;

    fabric_cfg_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .en     (emit),
        .bit_in (emit_bit),
        .crc    (crc)
    );
`endif

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: two loaders (CHAIN_LEN 8 and 6, WORD_W 4) driven by the
// same host stimulus and checked cycle by cycle against a timing model built
// from the host's valid schedule. CRC checks compile in with FABRIC_CFG_LOADER_CRC_EN.

module tb_fabric_cfg_loader;

    localparam int W    = 4;
    localparam int CL_A = 8;
    localparam int CL_B = 6;
    localparam int MAXC = 80;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         word_valid = 1'b0;
    logic [W-1:0] word_in = '0;

    logic rdy_a, so_a, cen_a, cset_a, busy_a, done_a;
    logic rdy_b, so_b, cen_b, cset_b, busy_b, done_b;
`ifdef FABRIC_CFG_LOADER_CRC_EN
    logic [15:0] crc_a, crc_b;
`endif

    logic [1:0] o_rdy, o_so, o_cen, o_cset, o_busy, o_done;
    assign o_rdy  = {rdy_b, rdy_a};
    assign o_so   = {so_b, so_a};
    assign o_cen  = {cen_b, cen_a};
    assign o_cset = {cset_b, cset_a};
    assign o_busy = {busy_b, busy_a};
    assign o_done = {done_b, done_a};

    int n_checks = 0;
    int n_pass   = 0;

    bit           vsched [0:MAXC-1];
    logic [W-1:0] words  [0:3];
    bit           e_cen  [0:1][0:MAXC-1];
    bit           e_bit  [0:1][0:MAXC-1];
    bit           e_rdy  [0:1][0:MAXC-1];
    bit           e_cset [0:1][0:MAXC-1];
    bit           e_done [0:1][0:MAXC-1];
    bit           e_busy [0:1][0:MAXC-1];
    int           e_last [0:1];
    logic [15:0]  e_stream [0:1];
    int           acc_a [0:3];
    int           n_acc_a;

    always #5 clk = ~clk;

    fabric_cfg_loader #(.WORD_W(W), .CHAIN_LEN(CL_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy_a), .shift_out(so_a), .cen(cen_a), .cset(cset_a), .busy(busy_a), .done(done_a)
`ifdef FABRIC_CFG_LOADER_CRC_EN
        , .crc(crc_a)
`endif
    );

    fabric_cfg_loader #(.WORD_W(W), .CHAIN_LEN(CL_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy_b), .shift_out(so_b), .cen(cen_b), .cset(cset_b), .busy(busy_b), .done(done_b)
`ifdef FABRIC_CFG_LOADER_CRC_EN
        , .crc(crc_b)
`endif
    );

`ifdef FABRIC_CFG_LOADER_CRC_EN
    // CRC as a polynomial remainder: (M(x)*x^16 + INIT(x)*x^n) mod P.
    function automatic logic [15:0] crc_model(input logic [15:0] stream, input int n);
        logic [63:0] v;
        v = 64'hFFFF << n;
        for (int i = 0; i < n; i++) v[n - 1 - i + 16] = v[n - 1 - i + 16] ^ stream[i];
        for (int d = n + 15; d >= 16; d--) if (v[d]) v = v ^ (64'h11021 << (d - 16));
        return v[15:0];
    endfunction
`endif

    // Timing model: the loader wants a word from cycle 1 and again W cycles after
    // each accept; the word's bits appear on the W cycles after its accept.
    task automatic build_model(input int k, input int cl);
        int need, acc, sent, w;
        for (int c = 0; c < MAXC; c++) begin
            e_cen[k][c] = 0; e_bit[k][c] = 0; e_rdy[k][c] = 0;
            e_cset[k][c] = 0; e_done[k][c] = 0; e_busy[k][c] = 0;
        end
        need = 1; sent = 0; w = 0; e_stream[k] = '0; e_last[k] = 1;
        while (sent < cl && w < 4) begin
            acc = need;
            while (!vsched[acc] && acc < MAXC - 20) acc++;
            for (int c = need; c <= acc; c++) e_rdy[k][c] = 1;
            if (k == 0) begin acc_a[w] = acc; n_acc_a = w + 1; end
            for (int b = 0; b < W && sent < cl; b++) begin
                e_cen[k][acc + 1 + b] = 1;
                e_bit[k][acc + 1 + b] = words[w][b];
                e_stream[k][sent] = words[w][b];
                sent++;
                e_last[k] = acc + 1 + b;
            end
            need = acc + W;
            w++;
        end
        e_cset[k][e_last[k] + 1] = 1;
        e_done[k][e_last[k] + 2] = 1;
        for (int c = 1; c <= e_last[k] + 2; c++) e_busy[k][c] = 1;
    endtask

    // Runs one load on both DUTs. mode 0: valid always high; 1: valid dropped in
    // cycles 5..7; 2: random valid. start is re-pulsed at start_extra (if >0).
    task automatic run_load(input int mode, input int start_extra,
                            output logic [15:0] s_a, output logic [15:0] s_b, output int cs_a);
        int ncyc, wi, hs_a, hs_b, na, nb;
`ifdef FABRIC_CFG_LOADER_CRC_EN
        logic [15:0] crc_ref;
`endif
        for (int c = 0; c < MAXC; c++) begin
            if (mode == 0)      vsched[c] = 1;
            else if (mode == 1) vsched[c] = !(c >= 5 && c <= 7);
            else                vsched[c] = (c >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        build_model(0, CL_A);
        build_model(1, CL_B);
        ncyc = e_last[0] + 6;
`ifdef FABRIC_CFG_LOADER_CRC_EN
        crc_ref = crc_model(e_stream[0], CL_A);
`endif
        s_a = '0; s_b = '0; na = 0; nb = 0; hs_a = 0; hs_b = 0; cs_a = -1;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == start_extra);
            word_valid = vsched[c];
            wi = 0;
            for (int j = 0; j < n_acc_a; j++) if (acc_a[j] < c) wi = j + 1;
            word_in = (wi < n_acc_a) ? words[wi] : W'($urandom);
            @(negedge clk);
            if (rdy_a && word_valid) hs_a++;
            if (rdy_b && word_valid) hs_b++;
            if (cen_a && na < 16) begin s_a[na] = so_a; na++; end
            if (cen_b && nb < 16) begin s_b[nb] = so_b; nb++; end
            if (cset_a && cs_a < 0) cs_a = c;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cen[k] !== e_cen[k][c]) $display("FAIL cen dut%0d cycle %0d: got %b expected %b", k, c, o_cen[k], e_cen[k][c]);
                else n_pass++;
                n_checks++;
                if (o_so[k] !== e_bit[k][c]) $display("FAIL shift_out dut%0d cycle %0d: got %b expected %b", k, c, o_so[k], e_bit[k][c]);
                else n_pass++;
                n_checks++;
                if (o_rdy[k] !== e_rdy[k][c]) $display("FAIL word_ready dut%0d cycle %0d: got %b expected %b", k, c, o_rdy[k], e_rdy[k][c]);
                else n_pass++;
                n_checks++;
                if (o_cset[k] !== e_cset[k][c]) $display("FAIL cset dut%0d cycle %0d: got %b expected %b", k, c, o_cset[k], e_cset[k][c]);
                else n_pass++;
                n_checks++;
                if (o_done[k] !== e_done[k][c]) $display("FAIL done dut%0d cycle %0d: got %b expected %b", k, c, o_done[k], e_done[k][c]);
                else n_pass++;
                n_checks++;
                if (o_busy[k] !== e_busy[k][c]) $display("FAIL busy dut%0d cycle %0d: got %b expected %b", k, c, o_busy[k], e_busy[k][c]);
                else n_pass++;
            end
`ifdef FABRIC_CFG_LOADER_CRC_EN
            if (c == 1) begin
                n_checks++;
                if (crc_a !== 16'hFFFF) $display("FAIL crc_init cycle %0d: got %h expected ffff", c, crc_a);
                else n_pass++;
            end
            if (c > e_last[0]) begin
                n_checks++;
                if (crc_a !== crc_ref) $display("FAIL crc cycle %0d: got %h expected %h", c, crc_a, crc_ref);
                else n_pass++;
            end
`endif
            @(posedge clk); #1;
        end
        start = 1'b0;
        word_valid = 1'b0;
        n_checks++;
        if (hs_a !== (CL_A + W - 1) / W) $display("FAIL handshakes dut0: got %0d expected %0d", hs_a, (CL_A + W - 1) / W);
        else n_pass++;
        n_checks++;
        if (hs_b !== (CL_B + W - 1) / W) $display("FAIL handshakes dut1: got %0d expected %0d", hs_b, (CL_B + W - 1) / W);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_rdy, o_so, o_cen, o_cset, o_busy, o_done} !== 12'h000)
            $display("FAIL reset_outputs: got %h expected 000", {o_rdy, o_so, o_cen, o_cset, o_busy, o_done});
        else n_pass++;
`ifdef FABRIC_CFG_LOADER_CRC_EN
        n_checks++;
        if (crc_a !== 16'hFFFF) $display("FAIL reset_crc: got %h expected ffff", crc_a);
        else n_pass++;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [15:0] s_a, s_b;
        int cs;
        words[0] = 4'hA; words[1] = 4'h5;
        run_load(0, -1, s_a, s_b, cs);
        n_checks++;
        if (s_a[7:0] !== 8'h5A) $display("FAIL basic_stream: got %h expected 5a", s_a[7:0]);
        else n_pass++;
        n_checks++;
        if (cs !== 2 + CL_A) $display("FAIL basic_cset_cycle: got %0d expected %0d", cs, 2 + CL_A);
        else n_pass++;
    endtask

    task automatic test_truncate;
        logic [15:0] s_a, s_b;
        int cs;
        words[0] = 4'hF; words[1] = 4'h3;
        run_load(0, -1, s_a, s_b, cs);
        n_checks++;
        if (s_b[5:0] !== 6'h3F) $display("FAIL truncate_stream: got %h expected 3f", s_b[5:0]);
        else n_pass++;
    endtask

    task automatic test_underrun;
        logic [15:0] s_a, s_b;
        int cs;
        words[0] = 4'h6; words[1] = 4'h9;
        run_load(1, -1, s_a, s_b, cs);
        n_checks++;
        if (s_a[7:0] !== 8'h96) $display("FAIL underrun_stream: got %h expected 96", s_a[7:0]);
        else n_pass++;
        n_checks++;
        if (cs !== 2 + CL_A + 3) $display("FAIL underrun_cset_cycle: got %0d expected %0d", cs, 5 + CL_A);
        else n_pass++;
    endtask

    task automatic test_start_during_load;
        logic [15:0] s_a, s_b;
        int cs;
        words[0] = W'($urandom); words[1] = W'($urandom);
        run_load(0, 4, s_a, s_b, cs);
        n_checks++;
        if (cs !== 2 + CL_A) $display("FAIL restart_cset_cycle: got %0d expected %0d", cs, 2 + CL_A);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        for (int c = 0; c < MAXC; c++) vsched[c] = 1;
        words[0] = W'($urandom); words[1] = W'($urandom);
        build_model(0, CL_A);
        build_model(1, CL_B);
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0);
            word_valid = 1'b1;
            word_in = (c <= acc_a[0]) ? words[0] : words[1];
            if (c == 6) begin rst = 1'b0; start = 1'b1; end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({o_cen[k], o_so[k]} !== {e_cen[k][c], e_bit[k][c]})
                    $display("FAIL preload dut%0d cycle %0d: got %b%b expected %b%b", k, c, o_cen[k], o_so[k], e_cen[k][c], e_bit[k][c]);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_rdy, o_so, o_cen, o_cset, o_busy, o_done} !== 12'h000)
            $display("FAIL midreset_outputs: got %h expected 000", {o_rdy, o_so, o_cen, o_cset, o_busy, o_done});
        else n_pass++;
`ifdef FABRIC_CFG_LOADER_CRC_EN
        n_checks++;
        if (crc_a !== 16'hFFFF) $display("FAIL midreset_crc: got %h expected ffff", crc_a);
        else n_pass++;
`endif
        @(posedge clk); #1;
        for (int c = 0; c < CL_A + 4; c++) begin
            word_in = W'($urandom);
            @(negedge clk);
            n_checks++;
            if ({o_cset, o_cen, o_busy, o_done, o_rdy} !== 10'h000)
                $display("FAIL midreset_idle cycle %0d: got %h expected 000", c, {o_cset, o_cen, o_busy, o_done, o_rdy});
            else n_pass++;
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] s_a, s_b;
        int cs;
        for (int r = 0; r < 6; r++) begin
            words[0] = W'($urandom); words[1] = W'($urandom);
            run_load(2, -1, s_a, s_b, cs);
            n_checks++;
            if (s_a[7:0] !== {words[1], words[0]}) $display("FAIL random_stream run %0d: got %h expected %h", r, s_a[7:0], {words[1], words[0]});
            else n_pass++;
        end
    endtask

    task automatic test_crc;
        logic [15:0] s_a, s_b;
        int cs;
        words[0] = 4'h1; words[1] = 4'h3;
        run_load(0, -1, s_a, s_b, cs);
        n_checks++;
        if (s_a[7:0] !== 8'h31) $display("FAIL crc_stream: got %h expected 31", s_a[7:0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_underrun();
        test_reset_mid_load();
        test_start_during_load();
        test_random();
        test_crc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
